pkt_tx_fifo: RTL and testbench

//   Transmit-side packet buffer placed directly upstream of the packet link top.

---
 rtl/pkt_tx_fifo.sv | 93 +++++++++
 tb/tb_pkt_tx_fifo.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/pkt_tx_fifo.sv
// Transmit-side packet FIFO, first-word-fall-through, with occupancy flags
// and sticky overflow/underflow error reporting. All outputs are registered.
module pkt_tx_fifo #(
  parameter int PK_W       = 32,
  parameter int DEPTH_LOG2 = 3,
  parameter int AF_LEVEL   = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [PK_W-1:0]       wr_data,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  read_req,
  output logic [PK_W-1:0]       packet_out,
  output logic                  buffer_empty,
  output logic [DEPTH_LOG2:0]   level,
  input  logic                  clr_err,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int LW = DEPTH_LOG2 + 1;
  localparam logic [LW-1:0] DEPTH_LVL = LW'(1 << DEPTH_LOG2);
  localparam logic [LW-1:0] AF_LVL    = LW'(AF_LEVEL);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  logic [PK_W-1:0]       mem_r [1 << DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2-1:0] wr_ptr_r;

  logic                  pop_ok_s;
  logic                  push_ok_s;
  logic                  ovf_evt_s;
  logic                  unf_evt_s;
  logic [DEPTH_LOG2-1:0] rd_ptr_nxt_s;
  logic [LW-1:0]         level_nxt_s;
  logic [PK_W-1:0]       head_nxt_s;

  // Next-state decode: handshakes, error events and the head word after this edge
  always_comb begin
    pop_ok_s     = read_req & ~buffer_empty;
    push_ok_s    = wr_en & (~full | pop_ok_s);
    ovf_evt_s    = wr_en & full & ~pop_ok_s;
    unf_evt_s    = read_req & buffer_empty;
    rd_ptr_nxt_s = pop_ok_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
    level_nxt_s  = level + LW'(push_ok_s) - LW'(pop_ok_s);
    head_nxt_s   = '0;
    // The word being written becomes the head when the read pointer lands on it.
    if (level_nxt_s == '0) begin
      head_nxt_s = '0;
    end else if (push_ok_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
      head_nxt_s = wr_data;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // Storage array write port; contents need no reset
  always_ff @(posedge clk) begin
    if (!rst && push_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers, occupancy, registered flags, head word and sticky errors
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r     <= '0;
      wr_ptr_r     <= '0;
      level        <= '0;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      buffer_empty <= 1'b1;
      packet_out   <= '0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      rd_ptr_r     <= rd_ptr_nxt_s;
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      level        <= level_nxt_s;
      full         <= (level_nxt_s == DEPTH_LVL);
      almost_full  <= (level_nxt_s >= AF_LVL);
      buffer_empty <= (level_nxt_s == '0);
      packet_out   <= head_nxt_s;
      overflow     <= ovf_evt_s | (overflow & ~clr_err);
      underflow    <= unf_evt_s | (underflow & ~clr_err);
    end
  end

endmodule

// File: tb/tb_pkt_tx_fifo.sv
// Bench for pkt_tx_fifo: directed boundary scenarios plus a randomized stream,
// all checked against a queue-based reference model.
module tb_pkt_tx_fifo;

  localparam int PK_W  = 32;
  localparam int DL    = 2;
  localparam int AF    = 3;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            wr_en = 1'b0;
  logic [PK_W-1:0] wr_data = '0;
  logic            read_req = 1'b0;
  logic            clr_err = 1'b0;
  logic            full;
  logic            almost_full;
  logic [PK_W-1:0] packet_out;
  logic            buffer_empty;
  logic [DL:0]     level;
  logic            overflow;
  logic            underflow;

  pkt_tx_fifo #(.PK_W(PK_W), .DEPTH_LOG2(DL), .AF_LEVEL(AF)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .almost_full(almost_full), .read_req(read_req), .packet_out(packet_out),
    .buffer_empty(buffer_empty), .level(level), .clr_err(clr_err),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [PK_W-1:0] q[$];
  logic ovf_m = 1'b0;
  logic unf_m = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock: drive inputs, advance the reference model, compare every output.
  task automatic step(input logic r, input logic we, input logic [31:0] d,
                      input logic rr, input logic cl);
    int   sz;
    logic pop;
    logic push;
    rst = r; wr_en = we; wr_data = d; read_req = rr; clr_err = cl;
    @(posedge clk);
    sz = q.size();
    if (r) begin
      q.delete();
      ovf_m = 1'b0;
      unf_m = 1'b0;
    end else begin
      pop  = rr && (sz > 0);
      push = we && ((sz < DEPTH) || pop);
      ovf_m = (we && (sz == DEPTH) && !pop) || (ovf_m && !cl);
      unf_m = (rr && (sz == 0)) || (unf_m && !cl);
      if (pop) void'(q.pop_front());
      if (push) q.push_back(d);
    end
    #1;
    check_val("level",     32'(level),        32'(q.size()));
    check_val("head",      packet_out,        (q.size() > 0) ? q[0] : 32'd0);
    check_val("empty",     32'(buffer_empty), 32'(q.size() == 0));
    check_val("full",      32'(full),         32'(q.size() == DEPTH));
    check_val("afull",     32'(almost_full),  32'(q.size() >= AF));
    check_val("overflow",  32'(overflow),     32'(ovf_m));
    check_val("underflow", 32'(underflow),    32'(unf_m));
  endtask

  initial begin
    // 1: reset then idle
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    check_val("s1_empty", 32'(buffer_empty), 32'd1);
    check_val("s1_out", packet_out, 32'd0);

    // 2: two pushes, two pops
    step(1'b0, 1'b1, 32'd32, 1'b0, 1'b0);
    check_val("s2_first", packet_out, 32'd32);
    check_val("s2_lvl1", 32'(level), 32'd1);
    step(1'b0, 1'b1, 32'd256, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    check_val("s2_second", packet_out, 32'd256);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    check_val("s2_drained", 32'(buffer_empty), 32'd1);

    // 3: fill, overflow, drain in order
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 1'b1, 32'(i), 1'b0, 1'b0);
      if (i == 3) check_val("s3_af", 32'(almost_full), 32'd1);
    end
    check_val("s3_full", 32'(full), 32'd1);
    step(1'b0, 1'b1, 32'd5, 1'b0, 1'b0);
    check_val("s3_ovf", 32'(overflow), 32'd1);
    check_val("s3_lvl", 32'(level), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      check_val("s3_order", packet_out, 32'(i));
      step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    end
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    check_val("s3_clr", 32'(overflow), 32'd0);

    // 4: push+pop while full, pointer wrap
    for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 32'(i), 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'd9, 1'b1, 1'b0);
    check_val("s4_lvl", 32'(level), 32'd4);
    check_val("s4_noovf", 32'(overflow), 32'd0);
    check_val("s4_head", packet_out, 32'd2);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    check_val("s4_last", packet_out, 32'd9);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);

    // 5: pop on empty with simultaneous push; clear; set-wins
    step(1'b0, 1'b1, 32'd7, 1'b1, 1'b0);
    check_val("s5_unf", 32'(underflow), 32'd1);
    check_val("s5_out", packet_out, 32'd7);
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    check_val("s5_clr", 32'(underflow), 32'd0);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    check_val("s5_setwins", 32'(underflow), 32'd1);
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);

    // 6: reset mid-operation discards contents
    for (int i = 11; i <= 13; i++) step(1'b0, 1'b1, 32'(i), 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'd99, 1'b1, 1'b0);
    check_val("s6_lvl", 32'(level), 32'd0);
    check_val("s6_empty", 32'(buffer_empty), 32'd1);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    check_val("s6_out", packet_out, 32'd0);
    step(1'b0, 1'b1, 32'd20, 1'b0, 1'b1);
    check_val("s6_new", packet_out, 32'd20);

    // Randomized stream with phases biased toward filling and draining
    for (int c = 0; c < 600; c++) begin
      int bias;
      logic r, we, rr, cl;
      bias = ((c / 75) % 2 == 0) ? 75 : 25;
      we = ($urandom_range(99) < 32'(bias));
      rr = ($urandom_range(99) < 32'(100 - bias));
      cl = ($urandom_range(15) == 0);
      r  = ($urandom_range(127) == 0);
      step(r, we, $urandom, rr, cl);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
